// File: rtl/mag_frame_tx_if.sv
// UART byte handshake between the magnitude framer (master) and uart_controller (slave).
interface mag_frame_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_LOAD;
  logic       TX_LOAD_OKAY;

  modport master (output TX_DATA, output TX_LOAD, input TX_LOAD_OKAY);
  modport slave  (input TX_DATA, input TX_LOAD, output TX_LOAD_OKAY);
endinterface

// File: rtl/mag_frame_tx.sv
// Serialises Goertzel magnitude snapshots into UART byte frames, with a 1-deep pending slot.
// Optional checksum byte before the terminating 0x0A: define MAG_FRAME_CHECKSUM_EN.
module mag_frame_tx #(
  parameter int GUARD_CYC = 2
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           G_READY,
  input  logic [15:0]    G0,
  input  logic [15:0]    G1,
  input  logic [4:0]     current_run,
  mag_frame_tx_if.master tx,
  output logic           busy,
  output logic [7:0]     drop_cnt
);

`ifdef MAG_FRAME_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif
  localparam int GUARD_LAST = (GUARD_CYC > 1) ? GUARD_CYC - 1 : 0;
  localparam int GW         = (GUARD_LAST > 0) ? $clog2(GUARD_LAST + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, GUARD, WAIT_OK, NEXT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      byte_idx_q;
  logic [GW-1:0]   guard_cnt_q;
  logic [4:0]      f_run_q, p_run_q;
  logic [15:0]     f_g0_q, f_g1_q, p_g0_q, p_g1_q;
  logic            p_vld_q;
  logic [7:0]      tx_data_q;
  logic            tx_load_q;
  logic [7:0]      drop_cnt_q;
  logic [7:0]      byte_sel;
  logic            load_fire, take_pend, take_live, pend_wr, pend_drop;
  logic            last_byte, guard_done;

  assign last_byte  = (byte_idx_q == LAST_IDX);
  assign guard_done = (guard_cnt_q == GW'(GUARD_LAST));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_fire = 1'b0;
    take_pend = 1'b0;
    take_live = 1'b0;
    case (state_q)
      IDLE: begin
        // An entry left in pending by a snapshot that landed on the final byte goes first.
        if (p_vld_q) begin
          take_pend = 1'b1;
          state_d   = LOAD;
        end else if (G_READY) begin
          take_live = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (tx.TX_LOAD_OKAY) begin
          load_fire = 1'b1;
          state_d   = GUARD;
        end
      end
      GUARD:   if (guard_done) state_d = WAIT_OK;
      WAIT_OK: if (tx.TX_LOAD_OKAY) state_d = NEXT;
      NEXT: begin
        if (!last_byte) begin
          state_d = LOAD;
        end else if (p_vld_q) begin
          take_pend = 1'b1;
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any snapshot not taken straight into the frame lands in pending.
  assign pend_wr   = G_READY && !take_live;
  assign pend_drop = pend_wr && p_vld_q && !take_pend;

`ifdef MAG_FRAME_CHECKSUM_EN
  logic [7:0] chk;
  // The two 0x2C separators cancel out of the XOR.
  assign chk = {3'b000, f_run_q} ^ f_g0_q[7:0] ^ f_g0_q[15:8] ^ f_g1_q[7:0] ^ f_g1_q[15:8];
`endif

  always_comb begin
    byte_sel = 8'h0A;
    case (byte_idx_q)
      4'd0:       byte_sel = {3'b000, f_run_q};
      4'd1, 4'd4: byte_sel = 8'h2C;
      4'd2:       byte_sel = f_g0_q[7:0];
      4'd3:       byte_sel = f_g0_q[15:8];
      4'd5:       byte_sel = f_g1_q[7:0];
      4'd6:       byte_sel = f_g1_q[15:8];
`ifdef MAG_FRAME_CHECKSUM_EN
      4'd7:       byte_sel = chk;
`endif
      default:    byte_sel = 8'h0A;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= '0;
      guard_cnt_q <= '0;
      f_run_q     <= '0;
      f_g0_q      <= '0;
      f_g1_q      <= '0;
      p_run_q     <= '0;
      p_g0_q      <= '0;
      p_g1_q      <= '0;
      p_vld_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      tx_load_q <= load_fire;
      if (load_fire) tx_data_q <= byte_sel;

      guard_cnt_q <= (state_q == GUARD && !guard_done) ? guard_cnt_q + GW'(1) : '0;

      if (state_q == NEXT) byte_idx_q <= last_byte ? 4'd0 : byte_idx_q + 4'd1;

      if (take_live) begin
        f_run_q <= current_run;
        f_g0_q  <= G0;
        f_g1_q  <= G1;
      end else if (take_pend) begin
        f_run_q <= p_run_q;
        f_g0_q  <= p_g0_q;
        f_g1_q  <= p_g1_q;
      end

      if (pend_wr) begin
        p_run_q <= current_run;
        p_g0_q  <= G0;
        p_g1_q  <= G1;
        p_vld_q <= 1'b1;
      end else if (take_pend) begin
        p_vld_q <= 1'b0;
      end

      if (pend_drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign busy       = (state_q != IDLE);
  assign tx.TX_DATA = tx_data_q;
  assign tx.TX_LOAD = tx_load_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_mag_frame_tx.sv
// Directed bench for mag_frame_tx: frame content, UART back-pressure, pending/drop, reset abort.
module tb_mag_frame_tx;
`ifdef MAG_FRAME_CHECKSUM_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic        sys_clk;
  logic        rst_n;
  logic        g_ready;
  logic [15:0] g0, g1;
  logic [4:0]  run;
  logic        busy;
  logic [7:0]  drop_cnt;

  mag_frame_tx_if u_if ();

  mag_frame_tx #(.GUARD_CYC(2)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .G_READY     (g_ready),
    .G0          (g0),
    .G1          (g1),
    .current_run (run),
    .tx          (u_if),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  logic [7:0] rx_q [$];
  int         viol_okay, viol_consec, viol_stable;
  logic       prev_load, neg_load;
  logic [7:0] last_data;
  int         uart_mode = 0;   // 0: OKAY high, 1: drop 100 cycles after each load, 2: OKAY low
  int         n_cmp = 0;
  int         n_err = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Byte monitor: records every load and counts protocol violations.
  initial begin
    prev_load = 1'b0; neg_load = 1'b0; last_data = 8'h00;
    viol_okay = 0; viol_consec = 0; viol_stable = 0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        last_data = 8'h00;
      end else if (u_if.TX_LOAD === 1'b1) begin
        rx_q.push_back(u_if.TX_DATA);
        if (u_if.TX_LOAD_OKAY !== 1'b1) viol_okay++;
        if (prev_load) viol_consec++;
        last_data = u_if.TX_DATA;
      end else if (u_if.TX_DATA !== last_data) begin
        viol_stable++;
      end
      prev_load = (u_if.TX_LOAD === 1'b1);
      neg_load  = prev_load;
    end
  end

  // UART model: reacts one edge after it sees a load.
  initial begin
    int hold;
    hold = 0;
    u_if.TX_LOAD_OKAY = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      if (uart_mode == 0) begin
        u_if.TX_LOAD_OKAY = 1'b1; hold = 0;
      end else if (uart_mode == 2) begin
        u_if.TX_LOAD_OKAY = 1'b0; hold = 0;
      end else if (neg_load) begin
        u_if.TX_LOAD_OKAY = 1'b0; hold = 100;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) u_if.TX_LOAD_OKAY = 1'b1;
      end else begin
        u_if.TX_LOAD_OKAY = 1'b1;
      end
    end
  end

  function automatic logic [7:0] fbyte(input int i, input logic [4:0] r,
                                       input logic [15:0] a, input logic [15:0] b);
    logic [7:0] t [0:6];
    t = '{{3'b000, r}, 8'h2C, a[7:0], a[15:8], 8'h2C, b[7:0], b[15:8]};
    if (i < 7) return t[i];
`ifdef MAG_FRAME_CHECKSUM_EN
    if (i == 7) return t[0] ^ t[1] ^ t[2] ^ t[3] ^ t[4] ^ t[5] ^ t[6];
`endif
    return 8'h0A;
  endfunction

  function automatic logic [7:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 8'hxx;
  endfunction

  task automatic do_reset();
    g_ready = 1'b0; uart_mode = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic pulse(input logic [4:0] r, input logic [15:0] a, input logic [15:0] b);
    @(posedge sys_clk); #1;
    run = r; g0 = a; g1 = b; g_ready = 1'b1;
    @(posedge sys_clk); #1;
    g_ready = 1'b0; run = 5'h1F; g0 = 16'hDEAD; g1 = 16'hBEEF;
  endtask

  task automatic wait_rx(input int target, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk); #1;
      if (rx_q.size() >= target) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (u_if.TX_LOAD !== 1'b0) begin n_err++; $display("FAIL reset_tx_load: got %b want 0", u_if.TX_LOAD); end
    n_cmp++; if (u_if.TX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", u_if.TX_DATA); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL reset_drop_cnt: got %h want 00", drop_cnt); end
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [0:FLEN-1];
    int base;
    bit to;
`ifdef MAG_FRAME_CHECKSUM_EN
    exp = '{8'h05, 8'h2C, 8'h34, 8'h12, 8'h2C, 8'hCD, 8'hAB, 8'h45, 8'h0A};
`else
    exp = '{8'h05, 8'h2C, 8'h34, 8'h12, 8'h2C, 8'hCD, 8'hAB, 8'h0A};
`endif
    do_reset();
    base = rx_q.size();
    pulse(5'd5, 16'h1234, 16'hABCD);
    @(negedge sys_clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_capture: got %b want 1", busy); end
    n_cmp++; if (u_if.TX_LOAD !== 1'b0) begin n_err++; $display("FAIL basic_load_cycle1: got %b want 0", u_if.TX_LOAD); end
    @(negedge sys_clk);
    n_cmp++; if (u_if.TX_LOAD !== 1'b1) begin n_err++; $display("FAIL basic_first_load_latency: got %b want 1", u_if.TX_LOAD); end
    n_cmp++; if (u_if.TX_DATA !== 8'h05) begin n_err++; $display("FAIL basic_first_byte: got %h want 05", u_if.TX_DATA); end
    wait_rx(base + FLEN, 200, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout: got %0d bytes want %0d", rx_q.size() - base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_cmp++; if (rx_at(base + i) !== exp[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, rx_at(base + i), exp[i]); end
    end
    repeat (8) @(negedge sys_clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_after_frame: busy got %b want 0", busy); end
    n_cmp++; if (rx_q.size() !== base + FLEN) begin n_err++; $display("FAIL basic_byte_count: got %0d want %0d", rx_q.size() - base, FLEN); end
    n_cmp++; if (viol_consec !== 0) begin n_err++; $display("FAIL basic_consecutive_loads: got %0d want 0", viol_consec); end
  endtask

  task automatic test_uart_slow();
    int base;
    bit to;
    do_reset();
    uart_mode = 1;
    base = rx_q.size();
    pulse(5'h1A, 16'hBEEF, 16'h0F0F);
    wait_rx(base + FLEN, 2500, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL slow_timeout: got %0d bytes want %0d", rx_q.size() - base, FLEN); end
    repeat (120) @(negedge sys_clk);
    n_cmp++; if (rx_q.size() !== base + FLEN) begin n_err++; $display("FAIL slow_load_count: got %0d want %0d", rx_q.size() - base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_cmp++; if (rx_at(base + i) !== fbyte(i, 5'h1A, 16'hBEEF, 16'h0F0F)) begin n_err++; $display("FAIL slow_byte%0d: got %h want %h", i, rx_at(base + i), fbyte(i, 5'h1A, 16'hBEEF, 16'h0F0F)); end
    end
    n_cmp++; if (viol_okay !== 0) begin n_err++; $display("FAIL slow_load_while_not_ok: got %0d want 0", viol_okay); end
    n_cmp++; if (viol_consec !== 0) begin n_err++; $display("FAIL slow_consecutive_loads: got %0d want 0", viol_consec); end
    n_cmp++; if (viol_stable !== 0) begin n_err++; $display("FAIL slow_tx_data_stable: got %0d changes want 0", viol_stable); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL slow_idle: busy got %b want 0", busy); end
    uart_mode = 0;
  endtask

  task automatic test_overwrite();
    int base;
    bit to;
    do_reset();
    base = rx_q.size();
    pulse(5'd1, 16'h0001, 16'h0011);
    repeat (5) @(posedge sys_clk);
    pulse(5'd2, 16'h0002, 16'h0022);
    repeat (5) @(posedge sys_clk);
    pulse(5'd3, 16'h0003, 16'h0033);
    @(negedge sys_clk);
    n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovw_drop_cnt: got %0d want 1", drop_cnt); end
    wait_rx(base + 2 * FLEN, 400, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL ovw_timeout: got %0d bytes want %0d", rx_q.size() - base, 2 * FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_cmp++; if (rx_at(base + i) !== fbyte(i, 5'd1, 16'h0001, 16'h0011)) begin n_err++; $display("FAIL ovw_f1_byte%0d: got %h want %h", i, rx_at(base + i), fbyte(i, 5'd1, 16'h0001, 16'h0011)); end
      n_cmp++; if (rx_at(base + FLEN + i) !== fbyte(i, 5'd3, 16'h0003, 16'h0033)) begin n_err++; $display("FAIL ovw_f2_byte%0d: got %h want %h", i, rx_at(base + FLEN + i), fbyte(i, 5'd3, 16'h0003, 16'h0033)); end
    end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovw_drop_cnt_end: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_saturate();
    int base;
    bit to;
    do_reset();
    uart_mode = 2;
    repeat (2) @(posedge sys_clk);
    base = rx_q.size();
    pulse(5'd0, 16'h0000, 16'h0000);
    for (int k = 1; k <= 301; k++) begin
      pulse(5'(k), 16'(k), ~16'(k));
      if (k == 11) begin
        n_cmp++; if (drop_cnt !== 8'd10) begin n_err++; $display("FAIL sat_drop_cnt_10: got %0d want 10", drop_cnt); end
      end
    end
    @(negedge sys_clk);
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_drop_cnt_max: got %h want ff", drop_cnt); end
    n_cmp++; if (rx_q.size() !== base) begin n_err++; $display("FAIL sat_no_load_while_blocked: got %0d loads want 0", rx_q.size() - base); end
    uart_mode = 0;
    wait_rx(base + 2 * FLEN, 400, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL sat_timeout: got %0d bytes want %0d", rx_q.size() - base, 2 * FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_cmp++; if (rx_at(base + FLEN + i) !== fbyte(i, 5'd13, 16'd301, ~16'd301)) begin n_err++; $display("FAIL sat_f2_byte%0d: got %h want %h", i, rx_at(base + FLEN + i), fbyte(i, 5'd13, 16'd301, ~16'd301)); end
    end
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_drop_cnt_hold: got %h want ff", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit to;
    do_reset();
    base = rx_q.size();
    pulse(5'd7, 16'h5566, 16'h7788);
    wait_rx(base + 3, 100, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL rmid_timeout: got %0d bytes want 3", rx_q.size() - base); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (u_if.TX_LOAD !== 1'b0) begin n_err++; $display("FAIL rmid_tx_load: got %b want 0", u_if.TX_LOAD); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge sys_clk);
    n_cmp++; if (rx_q.size() !== base + 3) begin n_err++; $display("FAIL rmid_no_more_bytes: got %0d want 3", rx_q.size() - base); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle: busy got %b want 0", busy); end
    pulse(5'd9, 16'h0102, 16'h0304);
    wait_rx(base + 3 + FLEN, 200, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL rmid_new_timeout: got %0d bytes want %0d", rx_q.size() - base - 3, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_cmp++; if (rx_at(base + 3 + i) !== fbyte(i, 5'd9, 16'h0102, 16'h0304)) begin n_err++; $display("FAIL rmid_byte%0d: got %h want %h", i, rx_at(base + 3 + i), fbyte(i, 5'd9, 16'h0102, 16'h0304)); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit to;
    for (int d = 0; d <= 6; d++) begin
      do_reset();
      base = rx_q.size();
      pulse(5'd2, 16'h1111, 16'h2222);
      wait_rx(base + FLEN, 200, to);
      repeat (d) @(posedge sys_clk);
      pulse(5'd4, 16'h3344 + 16'(d), 16'h5566);
      wait_rx(base + 2 * FLEN, 300, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL b2b_d%0d_timeout: got %0d bytes want %0d", d, rx_q.size() - base, 2 * FLEN); end
      for (int i = 0; i < FLEN; i++) begin
        n_cmp++; if (rx_at(base + FLEN + i) !== fbyte(i, 5'd4, 16'h3344 + 16'(d), 16'h5566)) begin n_err++; $display("FAIL b2b_d%0d_byte%0d: got %h want %h", d, i, rx_at(base + FLEN + i), fbyte(i, 5'd4, 16'h3344 + 16'(d), 16'h5566)); end
      end
      n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL b2b_d%0d_drop_cnt: got %0d want 0", d, drop_cnt); end
    end
  endtask

  initial begin
    rst_n = 1'b1; g_ready = 1'b0; run = '0; g0 = '0; g1 = '0;
    test_reset();
    test_basic();
    test_uart_slow();
    test_overwrite();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
